// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: memory-stage load/store unit.
//
// Sits between the Mstage op bus and the Wstage result bus and talks to a
// variable-latency request/response data memory. Accepts one op at a time:
// IDLE -> (REQ -> WAIT ->) DONE -> IDLE. Stores are lane-shifted onto a
// word-aligned address with byte strobes. Loads are extracted from the
// returned word and sign or zero extended.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready upstream op handshake; addr, wdata, wmask, wen, mvalid,
//                   mrtype are captured on acceptance
//   m_valid/m_ready downstream result handshake; rdata, m_fault stable
//                   while m_valid is high
//   mem_req_*       memory request (valid/ready, addr, wen, wdata, wstrb)
//   mem_rsp_*       one-cycle memory response (read data or write ack)
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word ops skip memory and report m_fault
//   undefined -> m_fault is 0; misaligned ops go to memory with the
//                lanes that fall past bit 31 dropped
module lsu_mem_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [7:0]            wmask,
  input  logic                  wen,
  input  logic                  mvalid,
  input  logic [2:0]            mrtype,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [1:0] off_q;
  logic [2:0] mrtype_q;
  logic       accept;
  logic       misalign;
  logic       unused_ok;

  assign accept        = s_valid && s_ready;
  assign s_ready       = (state == IDLE);
  assign m_valid       = (state == DONE);
  assign mem_req_valid = (state == REQ);

  // Only the low nibble of wmask carries strobes in the default build.
  assign unused_ok = ^wmask[7:4];

  function automatic logic [DATA_WIDTH-1:0] extract(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            off,
    input logic [2:0]            rtype
  );
    logic [DATA_WIDTH-1:0] w;
    w = raw >> {off, 3'b000};
    case (rtype)
      3'd0:    extract = {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
      3'd1:    extract = {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
      3'd2:    extract = w;
      3'd3:    extract = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
      3'd4:    extract = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
      default: extract = '0;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  logic is_half;
  logic is_word;
  logic fault_q;

  // Stores size themselves by wmask, loads by mrtype.
  always_comb begin
    is_half  = 1'b0;
    is_word  = 1'b0;
    misalign = 1'b0;
    if (mvalid) begin
      if (wen) begin
        is_half = (wmask == 8'h03);
        is_word = (wmask == 8'h0F);
      end else begin
        is_half = (mrtype == 3'd1) || (mrtype == 3'd4);
        is_word = (mrtype == 3'd2);
      end
      misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= misalign;
    end else if (m_valid && m_ready) begin
      fault_q <= 1'b0;
    end
  end

  assign m_fault = fault_q;
`else
  assign misalign = 1'b0;
  assign m_fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_wen   <= 1'b0;
      off_q     <= '0;
      mrtype_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            off_q    <= addr[1:0];
            mrtype_q <= mrtype;
            if (!mvalid || misalign) begin
              state   <= DONE;
              rdata   <= '0;
              mem_wen <= 1'b0;
            end else begin
              state     <= REQ;
              mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wen   <= wen;
              mem_wdata <= wdata << {addr[1:0], 3'b000};
              mem_wstrb <= wmask[3:0] << addr[1:0];
            end
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          // mem_wen still holds the op type; a store response is only an ack.
          if (mem_rsp_valid) begin
            state <= DONE;
            rdata <= mem_wen ? '0 : extract(mem_rsp_data, off_q, mrtype_q);
          end
        end
        default: begin
          if (m_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Memory-stage load/store unit between the Mstage bus (upstream) and the Wstage bus (downstream).
- Replaces the zero-latency combinational data memory with a variable-latency request/response memory port.
- Performs byte-lane alignment of store data and strobes, and load extraction with sign/zero extension.
- Holds the downstream valid/ready handshake until the memory transaction completes.

Parameters:
- ADDR_WIDTH, 32, width of the address bus.
- DATA_WIDTH, 32, memory data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  upstream op valid
- s_ready  out  1  LSU can accept an op
- addr  in  ADDR_WIDTH  effective address (ALU result)
- wdata  in  32  store data, unaligned (rs2)
- wmask  in  8  store size code: 8'h01 byte, 8'h03 half, 8'h0F word
- wen  in  1  op is a store
- mvalid  in  1  op accesses memory; 0 means pass-through
- mrtype  in  3  load type: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu
- m_valid  out  1  result valid to Wstage
- m_ready  in  1  Wstage accepts result
- rdata  out  32  extended load data
- m_fault  out  1  misaligned-access flag
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_wen  out  1  write request
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  lane-shifted byte strobes
- mem_rsp_valid  in  1  read data / write ack valid, one cycle
- mem_rsp_data  in  32  raw read word

Behaviour:
- Reset: state IDLE; s_ready=1; m_valid, m_fault, mem_req_valid, mem_wen = 0; rdata, mem_addr, mem_wdata, mem_wstrb = 0.
- States:
  - IDLE: s_ready=1.
  - REQ: drive request.
  - WAIT: await response.
  - DONE: m_valid=1.
- Capture: all inputs are captured on the s_valid&&s_ready edge.
- Transitions:
  - IDLE, accept with mvalid=0 -> DONE; rdata=0. Latency: m_valid one cycle after accept.
  - IDLE, accept with mvalid=1 -> REQ.
  - REQ: mem_req_valid=1 with stable addr/wen/wdata/wstrb. On mem_req_ready -> WAIT.
  - WAIT: on mem_rsp_valid -> DONE. A load registers the extracted data. A store treats the response as an ack and sets rdata=0.
  - DONE: m_valid=1 with rdata/m_fault stable until m_ready; then -> IDLE.
- s_ready is low in REQ, WAIT and DONE, so there is no overlap. Minimum memory-op latency (req_ready and rsp_valid each one cycle after asserted): m_valid three cycles after accept.
- Lane shift, with off=addr[1:0]:
  - mem_wstrb = wmask[3:0] << off.
  - mem_wdata = wdata << (8*off).
  - Bytes shifted past bit 31 are dropped.
- Load extraction: word w = mem_rsp_data >> (8*off), then:
  - mrtype 0: sext w[7:0].
  - 1: sext w[15:0].
  - 2: w.
  - 3: zext w[7:0].
  - 4: zext w[15:0].
  - 5-7: 0.
- Bus rules:
  - A mem_rsp_valid seen in IDLE, REQ or DONE is ignored.
  - mem_req_ready outside REQ is ignored.
  - mem_rsp_valid in the same cycle as the REQ handshake is not accepted; the response must come at least one cycle later.
- Reset mid-operation: rst in any state returns to IDLE next cycle with the reset output values. The in-flight transaction is abandoned and its late response is discarded by the IDLE rule.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a memory op is misaligned if:
  - it is halfword (wmask=8'h03 store or mrtype 1/4) with addr[0]=1, or
  - it is word (wmask=8'h0F or mrtype 2) with addr[1:0]!=0.
  - Misaligned op: accept -> DONE directly; no memory request is issued; m_fault=1; rdata=0.
  - m_fault clears when the result handshake completes.
- Not defined: m_fault is tied 0. Misaligned ops go to memory with the shifted lanes truncated as above.

Test Plan:
- Pass-through: s_valid with mvalid=0, m_ready=1 -> m_valid exactly 1 cycle after accept; rdata=0; no mem_req_valid.
- Load lb at addr 0x80000003, rsp_data 0x80112233 -> rdata 0xFFFFFF80; mem_addr 0x80000000. Same with mrtype=3 -> rdata 0x00000080.
- Store sh wdata 0x0000ABCD, wmask 8'h03, addr 0x80000002 -> mem_wstrb 4'b1100, mem_wdata 0xABCD0000, mem_wen=1. m_valid only after mem_rsp_valid.
- Backpressure: mem_req_ready held low 5 cycles, then m_ready low 3 cycles after DONE -> request fields stable throughout; m_valid and rdata held; s_ready stays 0 until the result handshake.
- Reset during WAIT, then a stray mem_rsp_valid arrives in IDLE -> no m_valid; next lw at 0x80000004 returns its own response data 0x12345678.
- With LSU_MISALIGN_CHECK_EN: lw at 0x80000002 -> no mem_req_valid; m_valid one cycle after accept with m_fault=1.
